// File: rtl/onehot_stream_encoder.sv
// rtl/onehot_stream_encoder.sv - serial set-bit index encoder with valid/ready handshakes
// Optional ENC_COUNT_EN adds the out_remain pending-bit count port.
module onehot_stream_encoder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
`ifdef ENC_COUNT_EN
   output logic [IDX_W:0]   out_remain,
`endif
   output logic             zero_err
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t           state;
   logic [WIDTH-1:0] pending;
   logic             in_fire;
   logic             out_fire;
   logic             in_zero;

   always_comb begin
      out_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) out_idx = IDX_W'(i);
      end
   end

`ifdef ENC_COUNT_EN
   always_comb begin
      out_remain = '0;
      for (int i = 0; i < WIDTH; i++) begin
         out_remain = out_remain + (IDX_W + 1)'(pending[i]);
      end
   end
   assign out_last = (out_remain == (IDX_W + 1)'(1));
`else
   assign out_last = ((pending & (pending - 1'b1)) == '0) && (pending != '0);
`endif

   assign out_valid = (state == DRAIN);
   assign out_fire  = out_valid & out_ready;
   // A new word can be taken in the same cycle the final index of the old one leaves.
   assign in_ready  = (state == IDLE) | (out_fire & out_last);
   assign in_fire   = in_valid & in_ready;
   assign in_zero   = (in_data == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         zero_err <= 1'b0;
      end else begin
         zero_err <= in_fire & in_zero;
         case (state)
            IDLE: begin
               if (in_fire && !in_zero) begin
                  pending <= in_data;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  if (!out_last) begin
                     pending <= pending & (pending - 1'b1);
                  end else if (in_fire && !in_zero) begin
                     pending <= in_data;
                  end else begin
                     pending <= '0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               pending <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// tb/tb_onehot_stream_encoder.sv - directed and random checks against a queue-based index model
// Model: each accepted word becomes the list of its set-bit positions, emitted lowest first.
module tb_onehot_stream_encoder;

   localparam int WIDTH = 8;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             zero_err;
`ifdef ENC_COUNT_EN
   logic [IDX_W:0]   out_remain;
`endif

   int checks = 0;
   int failures = 0;
   int q[$];
   int log_q[$];
   logic zexp = 1'b0;

   onehot_stream_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_idx(out_idx),
      .out_last(out_last),
`ifdef ENC_COUNT_EN
      .out_remain(out_remain),
`endif
      .zero_err(zero_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: compare outputs against the model, advance the model, then step past the edge.
   task automatic cycle();
      logic exp_ready;
      @(negedge clk);
      exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, q.size() != 0);
      check("zero_err", zero_err, zexp);
      if (q.size() != 0) begin
         check("out_idx", out_idx, q[0]);
         check("out_last", out_last, q.size() == 1);
      end
`ifdef ENC_COUNT_EN
      check("out_remain", out_remain, q.size());
`endif
      zexp = 1'b0;
      if (q.size() != 0 && out_ready) begin
         log_q.push_back(q[0]);
         void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
         if (in_data == '0) zexp = 1'b1;
         for (int i = 0; i < WIDTH; i++) if (in_data[i]) q.push_back(i);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic rdy);
      in_valid = 1'b1;
      in_data = d;
      out_ready = rdy;
      cycle();
      in_valid = 1'b0;
      in_data = $urandom;
   endtask

   initial begin
      #3;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_zero_err", zero_err, 1'b0);
      check("rst_out_idx", out_idx, '0);
      check("rst_out_last", out_last, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // One-hot word
      log_q.delete();
      send(8'h20, 1'b1);
      cycle();
      check("onehot_n", log_q.size(), 1);
      check("onehot_idx", log_q[0], 5);

      // Multi-bit word
      log_q.delete();
      send(8'b1001_0010, 1'b1);
      repeat (3) cycle();
      check("multi_n", log_q.size(), 3);
      check("multi_0", log_q[0], 1);
      check("multi_1", log_q[1], 4);
      check("multi_2", log_q[2], 7);
      cycle();

      // Backpressure
      log_q.delete();
      send(8'h81, 1'b0);
      repeat (4) cycle();
      out_ready = 1'b1;
      repeat (2) cycle();
      check("bp_n", log_q.size(), 2);
      check("bp_0", log_q[0], 0);
      check("bp_1", log_q[1], 7);

      // Zero word
      send(8'h00, 1'b1);
      repeat (2) cycle();

      // Back-to-back words
      log_q.delete();
      send(8'h04, 1'b1);
      send(8'h03, 1'b1);
      repeat (3) cycle();
      check("b2b_n", log_q.size(), 3);
      check("b2b_0", log_q[0], 2);
      check("b2b_1", log_q[1], 0);
      check("b2b_2", log_q[2], 1);

      // Reset in the middle of an all-ones drain
      send(8'hFF, 1'b1);
      repeat (2) cycle();
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_zero_err", zero_err, 1'b0);
      q.delete();
      zexp = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) cycle();

      // All-ones word
      log_q.delete();
      send(8'hFF, 1'b1);
      repeat (8) cycle();
      check("ones_n", log_q.size(), 8);
      for (int i = 0; i < 8; i++) check("ones_idx", log_q[i], i);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         in_valid = $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0: in_data = '0;
            1: in_data = 8'h01 << $urandom_range(0, 7);
            2: in_data = 8'hFF;
            default: in_data = $urandom;
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) cycle();
      check("drain_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
